// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the pipeline register bank: RAW interlock from a
// 3-deep write scoreboard, mispredict flush sequencing and SLP sleep/wake.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int NUM_REGS     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [2:0]  dec_dst,
  input  logic [2:0]  dec_src,
  input  logic        dec_reads_dst,
  input  logic        dec_reads_src,
  input  logic        dec_writes_dst,
  input  logic        dec_writes_src,
  input  logic        dec_is_slp,
  input  logic        br_mispredict,
  input  logic        wake,
  input  logic        count_clr,
  output logic [7:0]  stall_o,
  output logic        clear_o,
  output logic        branch_fail_o,
  output logic        sleeping_o,
  output logic [15:0] stall_count_o
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_SLEEP} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t              state;
  logic [2:0]          flush_cnt;

  logic                vld_p0, vld_p1, vld_p2;
  logic [NUM_REGS-1:0] wmask_p0, wmask_p1, wmask_p2;
  logic                slp_p0, slp_p1, slp_p2;

  logic [NUM_REGS-1:0] dec_wmask;
  logic [NUM_REGS-1:0] inflight;
  logic                in_run;
  logic                raw;
  logic                slp_at_wb;
  logic                stall_any;
  logic                load_p0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decode: write mask of the candidate instruction and the interlock.
  always_comb begin
    dec_wmask = '0;
    if (dec_writes_dst) dec_wmask[dec_dst] = 1'b1;
    if (dec_writes_src) dec_wmask[dec_src] = 1'b1;
  end

  // Writeback lands on the edge, so the W entry still blocks a read in decode.
  assign inflight = ({NUM_REGS{vld_p0}} & wmask_p0)
                  | ({NUM_REGS{vld_p1}} & wmask_p1)
                  | ({NUM_REGS{vld_p2}} & wmask_p2);

  assign in_run    = (state == ST_RUN);
  assign slp_at_wb = vld_p2 & slp_p2;

  assign raw = dec_valid & in_run &
               ((dec_reads_dst & inflight[dec_dst]) |
                (dec_reads_src & inflight[dec_src]));

  assign stall_o       = {6'b0, sleeping_o | (in_run & slp_at_wb), raw};
  assign stall_any     = |stall_o;
  assign load_p0       = dec_valid & ~stall_any & ~clear_o;
  assign branch_fail_o = br_mispredict & ~reset;

  // Scoreboard E (_p0) -> M (_p1) -> W (_p2); shifts every cycle like the bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      wmask_p0 <= '0;
      wmask_p1 <= '0;
      wmask_p2 <= '0;
      slp_p0   <= 1'b0;
      slp_p1   <= 1'b0;
      slp_p2   <= 1'b0;
    end else begin
      vld_p0   <= load_p0;
      wmask_p0 <= load_p0 ? dec_wmask : '0;
      slp_p0   <= load_p0 & dec_is_slp;
      vld_p1   <= vld_p0;
      wmask_p1 <= wmask_p0;
      slp_p1   <= slp_p0;
      vld_p2   <= vld_p1;
      wmask_p2 <= wmask_p1;
      slp_p2   <= slp_p1;
    end
  end

  // Control FSM: a mispredict from any state restarts the flush window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      flush_cnt  <= '0;
      clear_o    <= 1'b0;
      sleeping_o <= 1'b0;
    end else if (br_mispredict) begin
      state      <= ST_FLUSH;
      flush_cnt  <= FLUSH_LOAD;
      clear_o    <= 1'b1;
      sleeping_o <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (slp_at_wb) begin
            state      <= ST_SLEEP;
            sleeping_o <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state   <= ST_RUN;
            clear_o <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        ST_SLEEP: begin
          if (wake) begin
            state      <= ST_RUN;
            sleeping_o <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          clear_o    <= 1'b0;
          sleeping_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_o <= '0;
    end else if (count_clr) begin
      stall_count_o <= '0;
    end else if (stall_any) begin
      stall_count_o <= sat_inc16(stall_count_o);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// compared every cycle against an instruction-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int NUM_REGS     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [2:0]  dec_dst;
  logic [2:0]  dec_src;
  logic        dec_reads_dst;
  logic        dec_reads_src;
  logic        dec_writes_dst;
  logic        dec_writes_src;
  logic        dec_is_slp;
  logic        br_mispredict;
  logic        wake;
  logic        count_clr;
  logic [7:0]  stall_o;
  logic        clear_o;
  logic        branch_fail_o;
  logic        sleeping_o;
  logic [15:0] stall_count_o;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .NUM_REGS    (NUM_REGS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_dst       (dec_dst),
    .dec_src       (dec_src),
    .dec_reads_dst (dec_reads_dst),
    .dec_reads_src (dec_reads_src),
    .dec_writes_dst(dec_writes_dst),
    .dec_writes_src(dec_writes_src),
    .dec_is_slp    (dec_is_slp),
    .br_mispredict (br_mispredict),
    .wake          (wake),
    .count_clr     (count_clr),
    .stall_o       (stall_o),
    .clear_o       (clear_o),
    .branch_fail_o (branch_fail_o),
    .sleeping_o    (sleeping_o),
    .stall_count_o (stall_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions by register number, plus how many
  // clear cycles remain and whether the core is asleep.
  typedef struct {
    bit v;
    int wd;
    int ws;
    bit slp;
  } instr_t;

  instr_t pipe [3];
  int     m_flush;
  bit     m_sleep;
  int     m_cnt;
  bit     e_raw, e_s1, e_clear;

  function automatic bit pending(input int r);
    for (int k = 0; k < 3; k++)
      if (pipe[k].v && (pipe[k].wd == r || pipe[k].ws == r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, wd: -1, ws: -1, slp: 1'b0};
    m_flush = 0;
    m_sleep = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_eval();
    bit run;
    e_clear = (m_flush > 0);
    run     = !e_clear && !m_sleep;
    e_raw   = dec_valid && run &&
              ((dec_reads_dst && pending(int'(dec_dst))) ||
               (dec_reads_src && pending(int'(dec_src))));
    e_s1    = m_sleep || (run && pipe[2].v && pipe[2].slp);
  endtask

  task automatic model_clock();
    instr_t n0;
    bit     stall_any;
    model_eval();
    stall_any = e_raw || e_s1;
    if (dec_valid && !stall_any && !e_clear)
      n0 = '{v: 1'b1, wd: dec_writes_dst ? int'(dec_dst) : -1,
             ws: dec_writes_src ? int'(dec_src) : -1, slp: dec_is_slp};
    else
      n0 = '{v: 1'b0, wd: -1, ws: -1, slp: 1'b0};
    if (count_clr) m_cnt = 0;
    else if (stall_any && m_cnt < 65535) m_cnt++;
    if (br_mispredict) begin
      m_flush = FLUSH_CYCLES;
      m_sleep = 1'b0;
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (m_sleep) begin
      if (wake) m_sleep = 1'b0;
    end else if (pipe[2].v && pipe[2].slp) begin
      m_sleep = 1'b1;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = n0;
  endtask

  task automatic idle();
    dec_valid = 0; dec_dst = 0; dec_src = 0;
    dec_reads_dst = 0; dec_reads_src = 0;
    dec_writes_dst = 0; dec_writes_src = 0; dec_is_slp = 0;
    br_mispredict = 0; wake = 0; count_clr = 0;
  endtask

  task automatic set_dec(input int v, input int d, input int s, input int rd, input int rs,
                         input int wd, input int ws, input int slp);
    dec_valid      = 1'(v);
    dec_dst        = 3'(d);
    dec_src        = 3'(s);
    dec_reads_dst  = 1'(rd);
    dec_reads_src  = 1'(rs);
    dec_writes_dst = 1'(wd);
    dec_writes_src = 1'(ws);
    dec_is_slp     = 1'(slp);
  endtask

  // One clock: compare every output against the model, then advance both.
  task automatic step();
    @(negedge clk);
    model_eval();
    check_eq("stall_o",  32'(stall_o),       32'({6'b0, e_s1, e_raw}));
    check_eq("clear_o",  32'(clear_o),       32'(e_clear));
    check_eq("bfail_o",  32'(branch_fail_o), 32'(br_mispredict));
    check_eq("sleep_o",  32'(sleeping_o),    32'(m_sleep));
    check_eq("count_o",  32'(stall_count_o), 32'(m_cnt));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", 32'(stall_o), 32'h0);
    check_eq("rst_clear", 32'(clear_o), 32'h0);
    check_eq("rst_bfail", 32'(branch_fail_o), 32'h0);
    check_eq("rst_sleep", 32'(sleeping_o), 32'h0);
    check_eq("rst_count", 32'(stall_count_o), 32'h0);
    reset = 1'b0;

    // Back-to-back dependency on R3
    set_dec(1, 3, 0, 1, 1, 1, 0, 0); step();
    set_dec(1, 4, 3, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("b2b_stall", 32'(stall_o), 32'h01);
      step();
    end
    #1 check_eq("b2b_go", 32'(stall_o), 32'h00);
    check_eq("b2b_count", 32'(stall_count_o), 32'd3);
    step();
    idle(); repeat (3) step();

    // Constant source selected: S field ignored
    set_dec(1, 3, 0, 0, 0, 1, 0, 0); step();
    set_dec(1, 5, 3, 1, 0, 1, 0, 0);
    #1 check_eq("rc_const", 32'(stall_o[0]), 32'h0);
    step();
    idle(); repeat (3) step();

    // LD R1,(R2)+ writes both fields
    set_dec(1, 1, 2, 0, 1, 1, 1, 0); step();
    set_dec(1, 6, 2, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("ldinc_stall", 32'(stall_o), 32'h01);
      step();
    end
    #1 check_eq("ldinc_go", 32'(stall_o), 32'h00);
    step();
    idle(); repeat (3) step();
    set_dec(1, 1, 2, 0, 1, 1, 1, 0); step();
    set_dec(1, 6, 5, 0, 1, 1, 0, 0);
    #1 check_eq("ldinc_other", 32'(stall_o), 32'h00);
    step();
    idle(); repeat (3) step();

    // Mispredict in the middle of a RAW stall
    set_dec(1, 3, 0, 0, 0, 1, 0, 0); step();
    set_dec(1, 4, 3, 0, 1, 1, 0, 0);
    #1 check_eq("mp_pre_stall", 32'(stall_o), 32'h01);
    step();
    br_mispredict = 1'b1;
    #1 check_eq("mp_bfail", 32'(branch_fail_o), 32'h1);
    check_eq("mp_clear_pre", 32'(clear_o), 32'h0);
    step();
    br_mispredict = 1'b0;
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      #1 check_eq("mp_clear", 32'(clear_o), 32'h1);
      check_eq("mp_bfail_off", 32'(branch_fail_o), 32'h0);
      check_eq("mp_raw_off", 32'(stall_o[0]), 32'h0);
      step();
    end
    #1 check_eq("mp_run_clear", 32'(clear_o), 32'h0);
    check_eq("mp_run_stall", 32'(stall_o), 32'h00);
    step();
    idle(); repeat (3) step();

    // SLP: sleep after reaching W, wake returns to RUN
    set_dec(1, 0, 0, 0, 0, 0, 0, 1); step();
    idle(); step(); step();
    #1 check_eq("slp_stall", 32'(stall_o), 32'h02);
    check_eq("slp_not_yet", 32'(sleeping_o), 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("slp_sleep", 32'(sleeping_o), 32'h1);
      check_eq("slp_hold", 32'(stall_o), 32'h02);
      step();
    end
    wake = 1'b1; step(); wake = 1'b0;
    #1 check_eq("wake_run", 32'(sleeping_o), 32'h0);
    check_eq("wake_stall", 32'(stall_o), 32'h00);
    step();

    // Saturate the stall counter while asleep, then clear it under a stall
    set_dec(1, 0, 0, 0, 0, 0, 0, 1); step();
    idle(); repeat (3) step();
    repeat (70000) begin
      @(posedge clk);
      model_clock();
    end
    #1 check_eq("cnt_sat", 32'(stall_count_o), 32'hFFFF);
    count_clr = 1'b1; step(); count_clr = 1'b0;
    #1 check_eq("cnt_clr", 32'(stall_count_o), 32'h0);
    step();
    #1 check_eq("cnt_restart", 32'(stall_count_o), 32'h1);
    wake = 1'b1; step(); wake = 1'b0; step();

    // Asynchronous reset during FLUSH
    br_mispredict = 1'b1; step(); br_mispredict = 1'b0;
    #1 check_eq("rflush_pre", 32'(clear_o), 32'h1);
    #1 reset = 1'b1;
    #1 check_eq("rflush_clear", 32'(clear_o), 32'h0);
    check_eq("rflush_stall", 32'(stall_o), 32'h00);
    check_eq("rflush_sleep", 32'(sleeping_o), 32'h0);
    check_eq("rflush_count", 32'(stall_count_o), 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    // Random traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      int rmax;
      rmax = ($urandom_range(0, 1) != 0) ? 3 : 7;
      dec_valid      = ($urandom_range(0, 3) != 0);
      dec_dst        = 3'($urandom_range(0, rmax));
      dec_src        = 3'($urandom_range(0, rmax));
      dec_reads_dst  = 1'($urandom_range(0, 1));
      dec_reads_src  = 1'($urandom_range(0, 1));
      dec_writes_dst = 1'($urandom_range(0, 1));
      dec_writes_src = ($urandom_range(0, 4) == 0);
      dec_is_slp     = ($urandom_range(0, 29) == 0);
      br_mispredict  = ($urandom_range(0, 19) == 0);
      wake           = ($urandom_range(0, 7) == 0);
      count_clr      = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
